// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-store FSM encoding, write payload and round-constant table.
package aes_pkg;

    localparam int unsigned KEY_WIDTH   = 128;
    localparam int unsigned NUM_ROUNDS  = 10;
    localparam int unsigned ROUND_IDX_W = 4;
    localparam int unsigned NUM_ENTRIES = NUM_ROUNDS + 1;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned PAR_W       = KEY_WIDTH / WORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } rks_state_t;

    typedef struct packed {
        logic [ROUND_IDX_W-1:0] addr;
        logic [KEY_WIDTH-1:0]   data;
    } rk_wr_t;

    localparam logic [7:0] RCON [NUM_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Even parity, one bit per 32-bit word of a round key.
    function automatic logic [PAR_W-1:0] word_parity(input logic [KEY_WIDTH-1:0] key);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < PAR_W; i++) begin
            p[i] = ^key[i*WORD_W +: WORD_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/rk_mem.sv
// (NUM_ROUNDS+1) x KEY_WIDTH round-key array with one write port and one registered read port.
// Define KEY_STORE_PARITY_EN to store and check one even-parity bit per 32-bit word.
module rk_mem
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ROUND_IDX_W-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]   wr_data,
    input  logic                   rd_en,
    input  logic [ROUND_IDX_W-1:0] rd_addr,
    input  logic                   rd_zero,
    input  logic                   rd_byp,
    input  logic [KEY_WIDTH-1:0]   byp_data,
    output logic [KEY_WIDTH-1:0]   rd_data,
    output logic                   par_err_c
);

    logic [KEY_WIDTH-1:0] mem [NUM_ENTRIES];
    logic                 rd_in_range_c;
    logic [KEY_WIDTH-1:0] rd_word_c;

    assign rd_in_range_c = 32'(rd_addr) < NUM_ENTRIES;
    assign rd_word_c     = rd_in_range_c ? mem[rd_addr] : '0;

    // Storage is deliberately not reset; entries are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : (rd_byp ? byp_data : rd_word_c);
        end
    end

`ifdef KEY_STORE_PARITY_EN
    logic [PAR_W-1:0] par [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par[wr_addr] <= word_parity(wr_data);
        end
    end

    assign par_err_c = rd_en && rd_in_range_c && (word_parity(rd_word_c) != par[rd_addr]);
`else
    assign par_err_c = 1'b0;
`endif

endmodule

// File: rtl/round_key_store.sv
// Captures the cipher key plus NUM_ROUNDS round keys and serves any of them by round index.
// Optional per-word parity protection of the store: define KEY_STORE_PARITY_EN.
module round_key_store
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic                   rk_valid_i,
    input  logic [ROUND_IDX_W-1:0] rk_round_i,
    input  logic [KEY_WIDTH-1:0]   rk_i,
    input  logic                   rd_en_i,
    input  logic [ROUND_IDX_W-1:0] rd_round_i,
    output logic [KEY_WIDTH-1:0]   rd_key_o,
    output logic                   rd_valid_o,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS);

    rks_state_t             state;
    rks_state_t             state_d;
    logic [ROUND_IDX_W-1:0] fill_cnt;
    logic [ROUND_IDX_W-1:0] fill_cnt_d;
    logic                   rk_hit_c;
    logic                   seq_err_c;
    logic                   wr_en_c;
    rk_wr_t                 wr_c;
    logic                   rd_byp_c;
    logic                   rd_ok_c;
    logic                   rd_err_c;
    logic                   par_err_c;
    logic                   err_d;
    logic                   ready_d;
    logic                   busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (load_i) begin
            state_d = FILL;
        end else if (state == FILL && rk_valid_i && rk_round_i == fill_cnt
                     && fill_cnt == LAST_ROUND) begin
            state_d = READY;
        end
    end

    // load_i wins over a same-cycle round key; reads are legal below fill_cnt or via write-through.
    always_comb begin
        rk_hit_c   = 1'b0;
        seq_err_c  = 1'b0;
        wr_en_c    = 1'b0;
        wr_c       = '0;
        fill_cnt_d = fill_cnt;
        rd_byp_c   = 1'b0;
        rd_ok_c    = 1'b0;
        rd_err_c   = 1'b0;
        err_d      = err_o;
        ready_d    = (state_d == READY);
        busy_d     = (state_d == FILL);

        if (!load_i && state == FILL && rk_valid_i) begin
            rk_hit_c  = (rk_round_i == fill_cnt);
            seq_err_c = (rk_round_i != fill_cnt);
        end

        if (load_i) begin
            wr_en_c    = 1'b1;
            wr_c.addr  = '0;
            wr_c.data  = key_in;
            fill_cnt_d = ROUND_IDX_W'(1);
        end else if (rk_hit_c) begin
            wr_en_c    = 1'b1;
            wr_c.addr  = fill_cnt;
            wr_c.data  = rk_i;
            fill_cnt_d = fill_cnt + ROUND_IDX_W'(1);
        end

        rd_byp_c = rd_en_i && wr_en_c && (rd_round_i == wr_c.addr);
        rd_ok_c  = rd_byp_c || (rd_round_i < fill_cnt);
        rd_err_c = rd_en_i && (!rd_ok_c || (!rd_byp_c && par_err_c));

        if (load_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_o | seq_err_c | rd_err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt   <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_valid_o <= 1'b0;
        end else begin
            fill_cnt   <= fill_cnt_d;
            ready_o    <= ready_d;
            busy_o     <= busy_d;
            err_o      <= err_d;
            rd_valid_o <= rd_en_i;
        end
    end

    rk_mem u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_c),
        .wr_addr   (wr_c.addr),
        .wr_data   (wr_c.data),
        .rd_en     (rd_en_i),
        .rd_addr   (rd_round_i),
        .rd_zero   (!rd_ok_c),
        .rd_byp    (rd_byp_c),
        .byp_data  (wr_c.data),
        .rd_data   (rd_key_o),
        .par_err_c (par_err_c)
    );

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: directed FIPS-197 scenarios plus randomized traffic
// checked against an entry-level model of the store. Parity scenario needs KEY_STORE_PARITY_EN.
module tb_round_key_store;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_READY = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_i;
    logic [127:0] key_in;
    logic         rk_valid_i;
    logic [3:0]   rk_round_i;
    logic [127:0] rk_i;
    logic         rd_en_i;
    logic [3:0]   rd_round_i;
    logic [127:0] rd_key_o;
    logic         rd_valid_o;
    logic         ready_o;
    logic         busy_o;
    logic         err_o;

    logic [127:0] fips [11];

    // Model: which entries hold a key from the current fill, and their values.
    logic [127:0] m_key [11];
    bit           m_written [11];
    bit           m_par_bad [11];
    int           m_state;
    int           m_next;
    logic         m_err;
    logic [127:0] m_rd_key;

    int n_assert = 0;
    int n_fail   = 0;

    round_key_store u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_i),
        .key_in     (key_in),
        .rk_valid_i (rk_valid_i),
        .rk_round_i (rk_round_i),
        .rk_i       (rk_i),
        .rd_en_i    (rd_en_i),
        .rd_round_i (rd_round_i),
        .rd_key_o   (rd_key_o),
        .rd_valid_o (rd_valid_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_valid);
        chk("rd_valid", 128'(rd_valid_o), 128'(exp_valid));
        chk("rd_key", rd_key_o, m_rd_key);
        chk("ready", 128'(ready_o), 128'(m_state == S_READY));
        chk("busy", 128'(busy_o), 128'(m_state == S_FILL));
        chk("err", 128'(err_o), 128'(m_err));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 11; i++) begin
            m_written[i] = 1'b0;
            m_par_bad[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; load_i = 1'b0; key_in = '0; rk_valid_i = 1'b0; rk_round_i = '0;
        rk_i = '0; rd_en_i = 1'b0; rd_round_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        m_state = S_IDLE; m_next = 0; m_err = 1'b0; m_rd_key = '0;
        check_outputs(1'b0);
    endtask

    // One clock of stimulus; the model predicts the outputs seen after the edge.
    task automatic cyc(input logic ld, input logic [127:0] k, input logic v, input logic [3:0] rr,
                       input logic [127:0] rk, input logic re, input logic [3:0] rdr);
        logic         wr;
        logic [3:0]   wa;
        logic [127:0] wd;
        logic         seq_e;
        logic         rd_e;
        load_i = ld; key_in = k; rk_valid_i = v; rk_round_i = rr; rk_i = rk;
        rd_en_i = re; rd_round_i = rdr;
        wr = 1'b0; wa = '0; wd = '0; seq_e = 1'b0; rd_e = 1'b0;
        if (ld) begin
            wr = 1'b1; wa = '0; wd = k;
        end else if (m_state == S_FILL && v) begin
            if (int'(rr) == m_next) begin
                wr = 1'b1; wa = rr; wd = rk;
            end else begin
                seq_e = 1'b1;
            end
        end
        if (re) begin
            if (wr && rdr == wa) begin
                m_rd_key = wd;
            end else if (rdr <= 4'd10 && m_written[rdr]) begin
                m_rd_key = m_key[rdr];
                if (m_par_bad[rdr]) rd_e = 1'b1;
            end else begin
                m_rd_key = '0;
                rd_e = 1'b1;
            end
        end
        if (ld) begin
            model_clear();
            m_state = S_FILL; m_next = 1; m_err = 1'b0;
        end else begin
            m_err = m_err | seq_e | rd_e;
        end
        if (wr) begin
            m_written[wa] = 1'b1; m_key[wa] = wd; m_par_bad[wa] = 1'b0;
            if (!ld) begin
                m_next++;
                if (wa == 4'd10) m_state = S_READY;
            end
        end
        @(posedge clk); #1;
        check_outputs(re);
        load_i = 1'b0; rk_valid_i = 1'b0; rd_en_i = 1'b0;
    endtask

    task automatic load(input logic [127:0] k);
        cyc(1'b1, k, 1'b0, 4'd0, '0, 1'b0, 4'd0);
    endtask

    task automatic feed(input int r);
        cyc(1'b0, '0, 1'b1, 4'(r), fips[r], 1'b0, 4'd0);
    endtask

    task automatic rd(input int r);
        cyc(1'b0, '0, 1'b0, 4'd0, '0, 1'b1, 4'(r));
    endtask

    initial begin
        logic         r_ld;
        logic         r_v;
        logic [3:0]   r_rr;
        logic         r_re;
        logic [3:0]   r_rdr;
        logic [127:0] r_key;

        fips[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        fips[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fips[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        fips[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        fips[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        fips[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        fips[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        fips[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        fips[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        fips[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        fips[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        do_reset();

        // In-order FIPS-197 fill, then read the last and first entries.
        load(fips[0]);
        for (int r = 1; r <= 10; r++) feed(r);
        chk("t1_ready", 128'(ready_o), 128'd1);
        rd(10);
        chk("t1_rd10", rd_key_o, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        rd(0);
        chk("t1_rd0", rd_key_o, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

        // Out-of-order round: error, no write, fill resumes once round 3 arrives.
        load(fips[0]);
        feed(1); feed(2); feed(4);
        chk("t2_err", 128'(err_o), 128'd1);
        chk("t2_busy", 128'(busy_o), 128'd1);
        rd(4);
        chk("t2_rd4_unwritten", rd_key_o, 128'd0);
        for (int r = 3; r <= 10; r++) feed(r);
        chk("t2_ready", 128'(ready_o), 128'd1);

        // Reset mid-fill aborts; a fresh fill completes.
        load(fips[0]);
        for (int r = 1; r <= 5; r++) feed(r);
        do_reset();
        chk("t3_ready_after_rst", 128'(ready_o), 128'd0);
        chk("t3_busy_after_rst", 128'(busy_o), 128'd0);
        load(fips[0]);
        for (int r = 1; r <= 10; r++) feed(r);
        chk("t3_ready", 128'(ready_o), 128'd1);
        rd(7);
        chk("t3_rd7", rd_key_o, fips[7]);

        // Reads while filling: behind fill, write-through, ahead of fill.
        load(fips[0]);
        feed(1); feed(2);
        rd(2);
        chk("t4_rd2", rd_key_o, fips[2]);
        chk("t4_rd2_err", 128'(err_o), 128'd0);
        cyc(1'b0, '0, 1'b1, 4'd3, fips[3], 1'b1, 4'd3);
        chk("t4_bypass", rd_key_o, fips[3]);
        rd(7);
        chk("t4_rd7", rd_key_o, 128'd0);
        chk("t4_rd7_err", 128'(err_o), 128'd1);

        // Back-to-back reverse-order reads in READY.
        for (int r = 4; r <= 10; r++) feed(r);
        for (int r = 10; r >= 0; r--) begin
            rd(r);
            chk("t5_rev_key", rd_key_o, fips[r]);
        end

`ifdef KEY_STORE_PARITY_EN
        // Corrupt one stored bit: data is returned as stored, err_o flags it.
        load(fips[0]);
        for (int r = 1; r <= 10; r++) feed(r);
        u_dut.u_mem.mem[5][0] = ~u_dut.u_mem.mem[5][0];
        m_key[5][0] = ~m_key[5][0];
        m_par_bad[5] = 1'b1;
        rd(5);
        chk("t6_par_err", 128'(err_o), 128'd1);
        chk("t6_par_valid", 128'(rd_valid_o), 128'd1);
`endif

        // Randomized traffic against the model.
        load({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            r_ld  = ($urandom_range(0, 39) == 0);
            r_v   = ($urandom_range(0, 2) != 0);
            r_rr  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_next);
            r_re  = ($urandom_range(0, 1) == 0);
            r_rdr = 4'($urandom_range(0, 12));
            r_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc(r_ld, r_key, r_v, r_rr, {$urandom(), $urandom(), $urandom(), $urandom()},
                r_re, r_rdr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
